// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac
//
// Converts a 5-bit sample stream from the upstream signal generator into a
// PWM bit stream. One PWM frame is 32 clock cycles; the sample is latched
// once per frame at the frame boundary. The high time per frame equals the
// latched sample (duty = sample/32).
//
// Compile-time option:
//   WAVE_PWM_CENTER_ALIGN_EN  undefined -> edge-aligned pulse (high at k < duty)
//                             defined   -> centre-aligned pulse
//                                          (high at lo <= k < lo+duty,
//                                           lo = (32-duty)>>1)
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   run enable
//   wave_in[4:0]  in   unsigned sample (0..31)
//   wave_valid    in   wave_in holds a usable sample this cycle
//   pwm_out       out  registered PWM bit stream
//   frame_start   out  one-cycle pulse in the first cycle of every frame
//   sample_stale  out  one-cycle pulse (first cycle of a frame) when the
//                      preceding boundary found wave_valid low
//   duty_q[4:0]   out  duty applied to the current frame
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | disabled (en low or just out of reset); cnt parked at 0,
//           | outputs low, duty_q held
//   ST_RUN  | frames running; cnt advances 0..31 and wraps
//
// All outputs are flops. The comb logic computes the values the outputs
// must show in the *next* cycle from the next counter and next duty, so
// the registered pwm_out lines up exactly with cnt in the same cycle.

module wave_pwm_dac (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] wave_in,
  input  logic       wave_valid,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       sample_stale,
  output logic [4:0] duty_q
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'd31;

  state_t     state_q;
  state_t     state_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [4:0] duty_d;
  logic       pwm_d;
  logic       frame_start_d;
  logic       sample_stale_d;
  logic       boundary;

  // Pulse shape: is position k of a frame high for the given duty?
  function automatic logic pwm_hit(input logic [4:0] k, input logic [4:0] duty);
`ifdef WAVE_PWM_CENTER_ALIGN_EN
    logic [5:0] lo;
    logic [5:0] hi_end;
    lo     = (6'd32 - {1'b0, duty}) >> 1;
    hi_end = lo + {1'b0, duty};
    return ({1'b0, k} >= lo) && ({1'b0, k} < hi_end);
`else
    return k < duty;
`endif
  endfunction

  // The only cycle in which wave_in / wave_valid are looked at.
  assign boundary = (state_q == ST_RUN) && (cnt_q == CNT_LAST) && en;

  // State register (plus counter, duty and output flops)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      duty_q       <= 5'd0;
      pwm_out      <= 1'b0;
      frame_start  <= 1'b0;
      sample_stale <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      duty_q       <= duty_d;
      pwm_out      <= pwm_d;
      frame_start  <= frame_start_d;
      sample_stale <= sample_stale_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = 5'd0;
    duty_d  = duty_q;
    if (en) begin
      state_d = ST_RUN;
      // Coming out of idle starts a fresh frame at 0; while running the
      // counter advances and wraps 31 -> 0 through natural overflow.
      if (state_q == ST_RUN) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
    if (boundary && wave_valid) begin
      duty_d = wave_in;
    end
  end

  // Output logic: values registered into the output flops at the next edge
  always_comb begin
    frame_start_d  = 1'b0;
    sample_stale_d = 1'b0;
    pwm_d          = 1'b0;
    if (en) begin
      frame_start_d = (cnt_d == 5'd0);
      pwm_d         = pwm_hit(cnt_d, duty_d);
    end
    sample_stale_d = boundary && !wave_valid;
  end

endmodule

// File: doc/wave_pwm_dac.md
WAVE_PWM_DAC -- requirements
Module: wave_pwm_dac

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 The block SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide port en, input, 1 bit: run enable.
REQ-004 The block SHALL provide port wave_in, input, 5 bits: unsigned sample from the upstream signal_generator (0..31).
REQ-005 The block SHALL provide port wave_valid, input, 1 bit: wave_in holds a usable sample this cycle.
REQ-006 The block SHALL provide port pwm_out, output, 1 bit: registered PWM bit stream, duty = sample/32.
REQ-007 The block SHALL provide port frame_start, output, 1 bit: one-cycle pulse in the first cycle of every PWM frame.
REQ-008 The block SHALL provide port sample_stale, output, 1 bit: one-cycle pulse when a frame boundary finds wave_valid low.
REQ-009 The block SHALL provide port duty_q, output, 5 bits: the duty value applied to the current frame.

Function
REQ-010 The block SHALL keep a 5-bit frame counter cnt that counts 0..31 and wraps 31->0 while en=1, so that one frame is 32 cycles.
REQ-011 While en=0, the block SHALL force cnt to 0 on the next edge, drive pwm_out low and frame_start low, and hold duty_q.
REQ-012 At a frame boundary (cnt=31, en=1) with wave_valid=1, the block SHALL load duty_q with wave_in; the new value governs the frame that starts on the next cycle.
REQ-013 At a frame boundary with wave_valid=0, the block SHALL keep duty_q unchanged and pulse sample_stale in the first cycle of the next frame.
REQ-014 The block SHALL ignore wave_in and wave_valid in every cycle other than the boundary cycle.
REQ-015 The block SHALL pulse frame_start in exactly those cycles where cnt=0 and en=1.
REQ-016 Edge-aligned mode: in the cycle where cnt=k, pwm_out SHALL be 1 exactly when k < duty_q.
- Result: high for duty_q cycles per frame.
- duty_q=0: constant low.
- duty_q=31: low only at k=31.
REQ-017 pwm_out SHALL be driven from a flop, with the compare pipelined so that REQ-016 holds cycle-exact; there SHALL be no combinational path from any input to any output.
REQ-018 When en rises, the block SHALL start a frame at cnt=0 with the held duty_q and assert frame_start in that cycle.

Reset
REQ-019 Asserting rst_n low SHALL immediately, without a clock, force the following, including mid-frame:
- cnt=0, duty_q=0
- pwm_out=0, frame_start=0, sample_stale=0
REQ-020 In the first cycle after rst_n deasserts with en=1, the block SHALL have cnt=0 and frame_start=1, and SHALL run the first frame with duty 0 (pwm_out low).

Configuration
REQ-021 The block SHALL select pulse alignment at compile time with macro WAVE_PWM_CENTER_ALIGN_EN.
- Undefined: edge-aligned behaviour per REQ-016.
- Defined: with lo=(32-duty_q)>>1, pwm_out SHALL be 1 exactly when lo <= k < lo+duty_q.
- Defined, examples: duty 16 gives high at k=8..23; duty 31 gives high at k=0..30; duty 0 gives constant low.
- High count per frame SHALL equal duty_q in both modes.

Verification
REQ-022 Reset, then en=1, wave_valid=1, wave_in=10 constant -> frame 1 pwm_out all low; frames 2+ high at k=0..9 and low at k=10..31; frame_start every 32 cycles.
REQ-023 wave_in=0 then 31 in successive boundaries -> a frame with zero high cycles, then a frame with exactly 31 high cycles and pwm_out low only at k=31.
REQ-024 duty_q=12, wave_valid=0 at the boundary -> duty_q stays 12, sample_stale pulses once at k=0, and the next frame again has 12 high cycles.
REQ-025 rst_n low at k=17 of a duty-20 frame -> pwm_out, duty_q and cnt go 0 before the next edge; after release, frame_start asserts in the first cycle.
REQ-026 en low for 5 cycles mid-frame -> pwm_out low and cnt at 0; on re-enable, a fresh frame with frame_start and unchanged duty_q.
REQ-027 Upstream triangle wave_in sweeping 0..31..0, with WAVE_PWM_CENTER_ALIGN_EN defined -> per-frame high count equals the latched sample, centred per REQ-021 (duty 16: k=8..23).
